// File: rtl/branch_predictor_table.sv
// Purpose : N-way tagged branch-target table, one inferred block RAM per way, with a hardware clear sweep.
// Latency : lookup result one cycle after an accepted lookup_en; updates land in the RAM at the accepting edge.
// Backpressure: ready=0 during the clear sweep; lookup_en/update_en are ignored (not queued) while not ready.
//
// Ports:
//   clk, rst_n (async, active-low), flush (restart clear sweep), ready (1 = IDLE)
//   lookup_en/lookup_index/lookup_tag -> lookup_valid/lookup_hit/lookup_data (next cycle)
//   update_en/update_way/update_index/update_tag/update_data (writes {1, tag, data} to masked ways)
// Optional feature macro: BP_TABLE_BYPASS_EN -- forwards a same-cycle, same-index update into the
//   lookup result. Without it the RAMs are read-old on a same-address collision.
module branch_predictor_table #(
    parameter int WAYS    = 2,
    parameter int ENTRIES = 512,
    parameter int TAG_W   = 10,
    parameter int DATA_W  = 32,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    output logic              ready,
    input  logic              lookup_en,
    input  logic [IDX_W-1:0]  lookup_index,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              lookup_valid,
    output logic [WAYS-1:0]   lookup_hit,
    output logic [DATA_W-1:0] lookup_data,
    input  logic              update_en,
    input  logic [WAYS-1:0]   update_way,
    input  logic [IDX_W-1:0]  update_index,
    input  logic [TAG_W-1:0]  update_tag,
    input  logic [DATA_W-1:0] update_data
);

    localparam int ENT_W = 1 + TAG_W + DATA_W;

    typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   clear_idx;
    logic               clearing;
    logic               lk_acc;
    logic               up_acc;
    logic               valid_q;
    logic [TAG_W-1:0]   tag_q;
    logic [ENT_W-1:0]   entry [WAYS];
    logic [WAYS-1:0]    hit_raw;
    logic [DATA_W-1:0]  data_raw;

    assign clearing = (state == S_CLEAR);
    assign lk_acc   = lookup_en && ready && !flush;
    assign up_acc   = update_en && ready && !flush;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_CLEAR;
            clear_idx <= '0;
        end else begin
            state <= state_nxt;
            if (flush)
                clear_idx <= '0;
            else if (clearing)
                clear_idx <= clear_idx + IDX_W'(1);
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = S_CLEAR;
        else if (clearing && clear_idx == IDX_W'(ENTRIES - 1))
            state_nxt = S_IDLE;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready = (state == S_IDLE);
    end

    // Lookup pipeline control: tag and valid travel alongside the RAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            valid_q <= lk_acc;
            if (lk_acc)
                tag_q <= lookup_tag;
        end
    end

`ifdef BP_TABLE_BYPASS_EN
    // Same-cycle update to the looked-up set: remember which ways were written
    // so the registered result can substitute the new entry for the stale RAM read.
    logic [WAYS-1:0]   fwd_way_q;
    logic [ENT_W-1:0]  fwd_ent_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_way_q <= '0;
            fwd_ent_q <= '0;
        end else if (lk_acc) begin
            fwd_way_q <= (up_acc && update_index == lookup_index) ? update_way : '0;
            fwd_ent_q <= {1'b1, update_tag, update_data};
        end
    end
`endif

    // ---------------- Per-way RAM banks ----------------
    for (genvar w = 0; w < WAYS; w++) begin : g_way
`ifdef BP_TABLE_BYPASS_EN
        logic [ENT_W-1:0] mem [ENTRIES];
`else
        (* rw_addr_collision = "no" *)
        logic [ENT_W-1:0] mem [ENTRIES];
`endif
        logic [ENT_W-1:0] rd_q;

        // No reset on the array or read register so the bank maps onto block RAM;
        // the clear sweep provides the initial contents.
        always_ff @(posedge clk) begin
            if (clearing)
                mem[clear_idx] <= '0;
            else if (up_acc && update_way[w])
                mem[update_index] <= {1'b1, update_tag, update_data};
            if (lk_acc)
                rd_q <= mem[lookup_index];
        end

`ifdef BP_TABLE_BYPASS_EN
        assign entry[w] = fwd_way_q[w] ? fwd_ent_q : rd_q;
`else
        assign entry[w] = rd_q;
`endif

        assign hit_raw[w] = entry[w][ENT_W-1] && (entry[w][DATA_W +: TAG_W] == tag_q);
    end

    // Lowest-numbered hitting way wins: scan high to low so low ways overwrite.
    always_comb begin
        data_raw = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_raw[w])
                data_raw = entry[w][DATA_W-1:0];
        end
    end

    // Gate with valid so reset and idle cycles present zeros rather than stale RAM output.
    assign lookup_valid = valid_q;
    assign lookup_hit   = valid_q ? hit_raw  : '0;
    assign lookup_data  = valid_q ? data_raw : '0;

endmodule
